// File: rtl/regfile_write_arbiter.sv
// Write-port sequencer for the 32x32 register file: round-robin ALU/memory
// writeback arbitration plus a zero-fill sweep after reset and on clear_req.
module regfile_write_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter int NUM_REGS       = 32,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_all,
    input  logic                  clear_req,
    input  logic                  alu_valid,
    input  logic [ADDR_WIDTH-1:0] alu_addr,
    input  logic [DATA_WIDTH-1:0] alu_data,
    output logic                  alu_ready,
    input  logic                  mem_valid,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_ready,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  busy
);

    typedef enum logic {ARB, CLEAR} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_REG = ADDR_WIDTH'(NUM_REGS - 1);
    localparam state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR : ARB;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   cnt;
    logic                    last_mem;
    logic                    alu_xfer, mem_xfer;
    logic [ADDR_WIDTH-1:0]   xfer_addr;
    logic [DATA_WIDTH-1:0]   xfer_data;

    // Readiness is purely combinational so a requester learns of its grant
    // in the same cycle; the pointer only matters when both are valid.
    always_comb begin
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        if (!rst_all && state == ARB && !clear_req) begin
            if (alu_valid && mem_valid) begin
                alu_ready = last_mem;
                mem_ready = !last_mem;
            end else begin
                alu_ready = alu_valid;
                mem_ready = mem_valid;
            end
        end
    end

    assign alu_xfer  = alu_valid && alu_ready;
    assign mem_xfer  = mem_valid && mem_ready;
    assign xfer_addr = alu_xfer ? alu_addr : mem_addr;
    assign xfer_data = alu_xfer ? alu_data : mem_data;
    assign busy      = (state == CLEAR);

    always_comb begin
        state_nxt = state;
        case (state)
            ARB:     if (clear_req) state_nxt = CLEAR;
            CLEAR:   if (!clear_req && cnt == LAST_REG) state_nxt = ARB;
            default: state_nxt = RESET_STATE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_all) begin
        if (rst_all) state <= RESET_STATE;
        else         state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst_all) begin
        if (rst_all) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            cnt      <= '0;
            last_mem <= 1'b1;
        end else if (state == CLEAR) begin
            rf_we    <= 1'b1;
            rf_waddr <= cnt;
            rf_wdata <= '0;
            if (clear_req || cnt == LAST_REG) cnt <= '0;
            else                              cnt <= cnt + 1'b1;
        end else begin
            rf_we <= 1'b0;
            if (clear_req) begin
                cnt <= '0;
            end else if (alu_xfer || mem_xfer) begin
                last_mem <= mem_xfer;
                // Register 0 is hardwired zero: complete the handshake, drop the write.
                if (xfer_addr != '0) begin
                    rf_we    <= 1'b1;
                    rf_waddr <= xfer_addr;
                    rf_wdata <= xfer_data;
                end
            end
        end
    end

endmodule
